dpus_sched: RTL and testbench
=============================

DPUS_SCHED -- requirements
Module: dpus_sched

Interface
REQ-001 Parameter: FPU_LAT, default 3, cycles an FPU-class op (ctrl[3]=1) is held on the DPUS before capture; legal range 1..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Ports: r0_valid, r1_valid  input  1  request valid, requester 0 / 1.
REQ-005 Ports: r0_ready, r1_ready  output  1  request accepted when valid & ready high in the same cycle.
REQ-006 Ports: r0_a, r0_b, r1_a, r1_b  input  32  operands.
REQ-007 Ports: r0_ctrl, r1_ctrl  input  4  DPUS control code; bit 3 selects FPU class, bits 2:0 the op.
REQ-008 Ports: dpus_a, dpus_b  output  32; dpus_ctrl  output  4  operands and control driven to the DPUS.
REQ-009 Ports: dpus_result, dpus_aux  input  32; dpus_flags  input  4  combinational DPUS outputs.
REQ-010 Ports: rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-011 Ports: rsp_id  output  1 (granted requester); rsp_result, rsp_aux  output  32; rsp_flags  output  4.
REQ-012 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states: IDLE, EXEC, DONE; one operation in flight at a time.
REQ-014 IDLE: r0_ready/r1_ready high only for the arbitration winner, only when that requester's valid is high; both low in EXEC and DONE.
REQ-015 Arbitration: one valid -> it wins; both valid -> round-robin, winner is the requester not granted last.
REQ-016 On acceptance: latch a, b, ctrl, id into operand registers; go to EXEC; load countdown = FPU_LAT-1 if ctrl[3], else 0.
REQ-017 dpus_a/dpus_b/dpus_ctrl are always driven from the operand registers, stable for the full EXEC duration.
REQ-018 EXEC: countdown != 0 -> decrement; countdown == 0 -> capture dpus_result, dpus_flags into rsp registers, go to DONE.
REQ-019 Capture of aux: dpus_aux for ALU-class ops; forced to 32'h0 for FPU-class ops.
REQ-020 Latency from acceptance edge to rsp_valid high: 2 cycles for ALU class, FPU_LAT+1 for FPU class.
REQ-021 DONE: rsp_valid high and rsp_* stable until rsp_ready sampled high; then IDLE; no new acceptance in that same cycle.
REQ-022 Requests arriving while not IDLE are not accepted and not lost; they are arbitrated upon returning to IDLE.
REQ-023 Requester may drop valid before acceptance; no state changes.

Reset
REQ-024 reset low asynchronously forces: state IDLE, rsp_valid 0, busy 0, r0_ready/r1_ready 0, operand and rsp registers 0, rsp_id 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-025 Reset mid-EXEC or mid-DONE drops the in-flight operation with no response.

Configuration
REQ-026 Macro DPUS_SCHED_STRICT_PRIO_EN defined: requester 0 always wins when both valid; last-grant pointer unused.
REQ-027 Macro undefined: round-robin per REQ-015.

Verification
REQ-028 Reset release, r0 ALU op a=5 b=3 ctrl=4'b0000 -> r0_ready 1 cycle, rsp_valid 2 cycles after acceptance, rsp_id 0, rsp_result = DPUS result, busy high throughout.
REQ-029 r1 FPU op ctrl=4'b1000, FPU_LAT=3 -> dpus_* stable 3 cycles, rsp_valid 4 cycles after acceptance, rsp_aux 0.
REQ-030 r0 and r1 valid continuously, rsp_ready tied 1 -> grants alternate 0,1,0,1 (undefined macro); all 0 (macro defined).
REQ-031 rsp_ready held low 5 cycles in DONE -> rsp_* unchanged, no ready to either requester, IDLE on cycle after rsp_ready high.
REQ-032 reset asserted during EXEC of FPU op -> next cycle IDLE, rsp_valid 0, no response ever issued for that op.

Source files
------------

// File: rtl/dpus_sched_if.sv
// Bundle of requester, DPUS and response signals for dpus_sched.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface dpus_sched_if;
    logic        r0_valid;
    logic        r0_ready;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic [3:0]  r0_ctrl;
    logic        r1_valid;
    logic        r1_ready;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic [3:0]  r1_ctrl;
    logic [31:0] dpus_a;
    logic [31:0] dpus_b;
    logic [3:0]  dpus_ctrl;
    logic [31:0] dpus_result;
    logic [31:0] dpus_aux;
    logic [3:0]  dpus_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [31:0] rsp_aux;
    logic [3:0]  rsp_flags;
    logic        busy;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_ctrl,
        input  r1_valid, r1_a, r1_b, r1_ctrl,
        input  dpus_result, dpus_aux, dpus_flags,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output dpus_a, dpus_b, dpus_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_aux, rsp_flags,
        output busy
    );

    modport master (
        output r0_valid, r0_a, r0_b, r0_ctrl,
        output r1_valid, r1_a, r1_b, r1_ctrl,
        output dpus_result, dpus_aux, dpus_flags,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  dpus_a, dpus_b, dpus_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_aux, rsp_flags,
        input  busy
    );
endinterface

// File: rtl/dpus_sched.sv
// Two-requester scheduler for a shared combinational DPUS, one operation in flight.
// Define DPUS_SCHED_STRICT_PRIO_EN for fixed priority to requester 0; default is round-robin.
module dpus_sched #(
    parameter int FPU_LAT = 3
) (
    input  logic          clk,
    input  logic          reset,
    dpus_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [3:0] FPU_CNT = 4'(FPU_LAT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [31:0] rsp_aux_q, rsp_aux_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp_id_q, rsp_id_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        busy_q;
    logic        win1_s;
    logic        gnt0_s;
    logic        gnt1_s;

    // Arbitration winner: 1 selects requester 1
    always_comb begin
        win1_s = 1'b0;
`ifdef DPUS_SCHED_STRICT_PRIO_EN
        win1_s = ~bus.r0_valid;
`else
        if (bus.r0_valid && bus.r1_valid) begin
            win1_s = ~last_q;
        end else begin
            win1_s = ~bus.r0_valid;
        end
`endif
    end

    // Next-state and datapath control
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        ctrl_d       = ctrl_q;
        id_d         = id_q;
        last_d       = last_q;
        rsp_result_d = rsp_result_q;
        rsp_aux_d    = rsp_aux_q;
        rsp_flags_d  = rsp_flags_q;
        rsp_id_d     = rsp_id_q;
        rsp_valid_d  = 1'b0;
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Ready is gated by reset so nothing is offered while reset is held
                if (reset && (bus.r0_valid || bus.r1_valid)) begin
                    gnt0_s  = ~win1_s;
                    gnt1_s  = win1_s;
                    a_d     = win1_s ? bus.r1_a    : bus.r0_a;
                    b_d     = win1_s ? bus.r1_b    : bus.r0_b;
                    ctrl_d  = win1_s ? bus.r1_ctrl : bus.r0_ctrl;
                    id_d    = win1_s;
                    last_d  = win1_s;
                    cnt_d   = ctrl_d[3] ? FPU_CNT : 4'd0;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_result_d = bus.dpus_result;
                    rsp_flags_d  = bus.dpus_flags;
                    rsp_aux_d    = ctrl_q[3] ? 32'h0000_0000 : bus.dpus_aux;
                    rsp_id_d     = id_q;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                // First DONE cycle raises rsp_valid; leave only after a seen handshake
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            a_q          <= 32'h0000_0000;
            b_q          <= 32'h0000_0000;
            ctrl_q       <= 4'd0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            rsp_result_q <= 32'h0000_0000;
            rsp_aux_q    <= 32'h0000_0000;
            rsp_flags_q  <= 4'd0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            ctrl_q       <= ctrl_d;
            id_q         <= id_d;
            last_q       <= last_d;
            rsp_result_q <= rsp_result_d;
            rsp_aux_q    <= rsp_aux_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp_id_q     <= rsp_id_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign bus.r0_ready   = gnt0_s;
    assign bus.r1_ready   = gnt1_s;
    assign bus.dpus_a     = a_q;
    assign bus.dpus_b     = b_q;
    assign bus.dpus_ctrl  = ctrl_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_aux    = rsp_aux_q;
    assign bus.rsp_flags  = rsp_flags_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_dpus_sched.sv
// Directed self-checking bench for dpus_sched with a small combinational DPUS model:
// result = a + b, aux = a ^ b, flags = ctrl ^ 4'hA.
module tb_dpus_sched;

    logic clk;
    logic reset;
    int   checks_n;
    int   fails_n;
    int   n;
    int   exp_g;
    logic strict_s;

    dpus_sched_if bus_if ();

    dpus_sched #(.FPU_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    assign bus_if.dpus_result = bus_if.dpus_a + bus_if.dpus_b;
    assign bus_if.dpus_aux    = bus_if.dpus_a ^ bus_if.dpus_b;
    assign bus_if.dpus_flags  = bus_if.dpus_ctrl ^ 4'hA;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_n++;
        if (act !== exp) begin
            fails_n++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count edges from acceptance until rsp_valid, checking DPUS operands hold meanwhile
    task automatic wait_rsp(input logic [31:0] ea, input logic [3:0] ec, output int cnt);
        cnt = 0;
        while (!bus_if.rsp_valid && cnt < 40) begin
            check_val("exec_dpus_a", bus_if.dpus_a, ea);
            check_val("exec_dpus_ctrl", 32'(bus_if.dpus_ctrl), 32'(ec));
            check_val("exec_busy", 32'(bus_if.busy), 32'd1);
            step();
            cnt++;
        end
    endtask

    initial begin
        checks_n = 0;
        fails_n  = 0;
`ifdef DPUS_SCHED_STRICT_PRIO_EN
        strict_s = 1'b1;
`else
        strict_s = 1'b0;
`endif
        reset            = 1'b0;
        bus_if.r0_valid  = 1'b1;
        bus_if.r0_a      = 32'd5;
        bus_if.r0_b      = 32'd3;
        bus_if.r0_ctrl   = 4'b0000;
        bus_if.r1_valid  = 1'b0;
        bus_if.r1_a      = 32'd0;
        bus_if.r1_b      = 32'd0;
        bus_if.r1_ctrl   = 4'b0000;
        bus_if.rsp_ready = 1'b0;
        step();
        step();

        // Reset state, with r0 already requesting
        check_val("rst_r0_ready", 32'(bus_if.r0_ready), 32'd0);
        check_val("rst_busy", 32'(bus_if.busy), 32'd0);
        check_val("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_val("rst_dpus_a", bus_if.dpus_a, 32'd0);
        check_val("rst_rsp_id", 32'(bus_if.rsp_id), 32'd0);
        check_val("rst_rsp_result", bus_if.rsp_result, 32'd0);

        // ALU op from r0
        reset = 1'b1;
        #1;
        check_val("alu_r0_ready", 32'(bus_if.r0_ready), 32'd1);
        check_val("alu_r1_ready", 32'(bus_if.r1_ready), 32'd0);
        step();
        bus_if.r0_valid = 1'b0;
        check_val("alu_r0_ready_off", 32'(bus_if.r0_ready), 32'd0);
        check_val("alu_dpus_b", bus_if.dpus_b, 32'd3);
        wait_rsp(32'd5, 4'b0000, n);
        check_val("alu_latency", 32'(n), 32'd2);
        check_val("alu_rsp_id", 32'(bus_if.rsp_id), 32'd0);
        check_val("alu_rsp_result", bus_if.rsp_result, 32'd8);
        check_val("alu_rsp_aux", bus_if.rsp_aux, 32'd6);
        check_val("alu_rsp_flags", 32'(bus_if.rsp_flags), 32'hA);
        check_val("alu_busy_done", 32'(bus_if.busy), 32'd1);
        bus_if.rsp_ready = 1'b1;
        step();
        check_val("alu_idle_busy", 32'(bus_if.busy), 32'd0);
        check_val("alu_idle_valid", 32'(bus_if.rsp_valid), 32'd0);
        bus_if.rsp_ready = 1'b0;

        // FPU op from r1
        bus_if.r1_valid = 1'b1;
        bus_if.r1_a     = 32'h10;
        bus_if.r1_b     = 32'h20;
        bus_if.r1_ctrl  = 4'b1000;
        #1;
        check_val("fpu_r1_ready", 32'(bus_if.r1_ready), 32'd1);
        check_val("fpu_r0_ready", 32'(bus_if.r0_ready), 32'd0);
        step();
        bus_if.r1_valid = 1'b0;
        wait_rsp(32'h10, 4'b1000, n);
        check_val("fpu_latency", 32'(n), 32'd4);
        check_val("fpu_rsp_id", 32'(bus_if.rsp_id), 32'd1);
        check_val("fpu_rsp_result", bus_if.rsp_result, 32'h30);
        check_val("fpu_rsp_aux", bus_if.rsp_aux, 32'd0);
        check_val("fpu_rsp_flags", 32'(bus_if.rsp_flags), 32'h2);

        // Back-pressure in DONE while both requesters wait
        bus_if.r0_valid = 1'b1;
        bus_if.r0_a     = 32'd1;
        bus_if.r0_b     = 32'd2;
        bus_if.r0_ctrl  = 4'b0000;
        bus_if.r1_valid = 1'b1;
        bus_if.r1_a     = 32'd100;
        bus_if.r1_b     = 32'd7;
        bus_if.r1_ctrl  = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("hold_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
            check_val("hold_rsp_result", bus_if.rsp_result, 32'h30);
            check_val("hold_rsp_id", 32'(bus_if.rsp_id), 32'd1);
            check_val("hold_r0_ready", 32'(bus_if.r0_ready), 32'd0);
            check_val("hold_r1_ready", 32'(bus_if.r1_ready), 32'd0);
            step();
        end
        bus_if.rsp_ready = 1'b1;
        step();
        check_val("hold_exit_busy", 32'(bus_if.busy), 32'd0);
        check_val("hold_exit_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_val("hold_exit_r0_ready", 32'(bus_if.r0_ready), 32'd1);
        check_val("hold_exit_r1_ready", 32'(bus_if.r1_ready), 32'd0);

        // Both valid, rsp_ready tied high: round-robin alternates, strict stays on r0
        for (int i = 0; i < 4; i++) begin
            exp_g = strict_s ? 0 : (i % 2);
            n = 0;
            while (!(bus_if.r0_ready || bus_if.r1_ready) && n < 20) begin
                step();
                n++;
            end
            check_val("alt_any_ready", 32'(bus_if.r0_ready | bus_if.r1_ready), 32'd1);
            check_val("alt_grant", 32'(bus_if.r1_ready), 32'(exp_g));
            step();
            wait_rsp((exp_g != 0) ? 32'd100 : 32'd1, 4'b0000, n);
            check_val("alt_latency", 32'(n), 32'd2);
            check_val("alt_rsp_id", 32'(bus_if.rsp_id), 32'(exp_g));
            check_val("alt_rsp_result", bus_if.rsp_result, (exp_g != 0) ? 32'd107 : 32'd3);
            step();
        end
        bus_if.r0_valid = 1'b0;
        bus_if.r1_valid = 1'b0;

        // Reset in the middle of an FPU op
        bus_if.r1_valid = 1'b1;
        bus_if.r1_a     = 32'd9;
        bus_if.r1_b     = 32'd9;
        bus_if.r1_ctrl  = 4'b1001;
        #1;
        check_val("rst_fpu_r1_ready", 32'(bus_if.r1_ready), 32'd1);
        step();
        bus_if.r1_valid = 1'b0;
        step();
        check_val("rst_fpu_busy_exec", 32'(bus_if.busy), 32'd1);
        reset = 1'b0;
        #1;
        check_val("rst_fpu_busy", 32'(bus_if.busy), 32'd0);
        check_val("rst_fpu_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
        check_val("rst_fpu_dpus_a", bus_if.dpus_a, 32'd0);
        check_val("rst_fpu_dpus_ctrl", 32'(bus_if.dpus_ctrl), 32'd0);
        step();
        reset = 1'b1;
        bus_if.r0_valid = 1'b1;
        bus_if.r1_valid = 1'b1;
        #1;
        check_val("rst_tie_r0_ready", 32'(bus_if.r0_ready), 32'd1);
        check_val("rst_tie_r1_ready", 32'(bus_if.r1_ready), 32'd0);
        bus_if.r0_valid = 1'b0;
        bus_if.r1_valid = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus_if.rsp_valid) n++;
        end
        check_val("rst_no_response", 32'(n), 32'd0);
        check_val("rst_final_busy", 32'(bus_if.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
        $finish;
    end

endmodule
